// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-requester round-robin APB master (IDLE/SETUP/ACCESS/DECERR)
//
// Purpose: arbitrates requester 0 (core LSU) and requester 1 (debug/DMA) onto one APB
// master port. Requests to the unmapped slot addr[15:13]==3'b000 are completed locally
// with an error instead of being issued on the bus.
// Optional feature macro: APB_TIMEOUT_EN (abort ACCESS after TIMEOUT_CYC cycles without ready).
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req{0,1}_valid/wr/addr/wdata    requester command, held until req{0,1}_ack
//   req{0,1}_ack                    one-cycle completion pulse
//   rsp_rdata, rsp_err              response of the last completed transfer
//   busy                            high whenever the FSM is not in IDLE
//   m_addr/m_wr/m_sel/m_enable/m_wdata   APB master outputs (registered)
//   m_ready/m_rdata/m_slverr        APB responses from the interconnect

module apb_master_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ack,
    input  logic              req1_valid,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ack,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wr,
    output logic              m_sel,
    output logic              m_enable,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_slverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;

    state_t state;
    logic   last_gnt;
    logic   gnt;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] to_cnt;
`endif

    // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
    logic              pick1;
    logic [ADDR_W-1:0] win_addr;
    assign pick1    = req1_valid && (!req0_valid || !last_gnt);
    assign win_addr = pick1 ? req1_addr : req0_addr;

    // Completion of the current transfer and the response it produces.
    logic              done;
    logic              done_err;
    logic [DATA_W-1:0] done_rdata;

    always_comb begin
        done       = 1'b0;
        done_err   = 1'b0;
        done_rdata = '0;
        case (state)
            ACCESS: begin
                if (m_ready) begin
                    done       = 1'b1;
                    done_err   = m_slverr;
                    done_rdata = m_wr ? '0 : m_rdata;
                end
`ifdef APB_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
`endif
            end
            DECERR: begin
                done     = 1'b1;
                done_err = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            gnt       <= 1'b0;
            req0_ack  <= 1'b0;
            req1_ack  <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            m_addr    <= '0;
            m_wr      <= 1'b0;
            m_sel     <= 1'b0;
            m_enable  <= 1'b0;
            m_wdata   <= '0;
`ifdef APB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        gnt      <= pick1;
                        last_gnt <= pick1;
                        m_addr   <= win_addr;
                        m_wr     <= pick1 ? req1_wr : req0_wr;
                        m_wdata  <= pick1 ? req1_wdata : req0_wdata;
                        busy     <= 1'b1;
                        if (win_addr[15:13] == 3'b000) begin
                            state <= DECERR;
                        end else begin
                            state <= SETUP;
                            m_sel <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    m_enable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    to_cnt   <= '0;
`endif
                end
                ACCESS: begin
`ifdef APB_TIMEOUT_EN
                    if (!m_ready) to_cnt <= to_cnt + 8'd1;
`endif
                end
                default: ;
            endcase
            // Shared completion path for normal, slave-error, decode-error and timeout ends.
            if (done) begin
                state     <= IDLE;
                busy      <= 1'b0;
                m_sel     <= 1'b0;
                m_enable  <= 1'b0;
                rsp_err   <= done_err;
                rsp_rdata <= done_rdata;
                req0_ack  <= !gnt;
                req1_ack  <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed self-checking bench for apb_master_arbiter

module tb_apb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_wr, req1_valid, req1_wr;
    logic [19:0] req0_addr, req1_addr;
    logic [31:0] req0_wdata, req1_wdata;
    logic        req0_ack, req1_ack;
    logic [31:0] rsp_rdata;
    logic        rsp_err, busy;
    logic [19:0] m_addr;
    logic        m_wr, m_sel, m_enable;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        m_slverr;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    apb_master_arbiter #(.ADDR_W(20), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ack(req0_ack),
        .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ack(req1_ack),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .m_addr(m_addr), .m_wr(m_wr), .m_sel(m_sel), .m_enable(m_enable),
        .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata), .m_slverr(m_slverr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0_valid = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0;
        m_ready = 0; m_rdata = '0; m_slverr = 0;
        tick(); tick();
        chk_cnt++;
        if ({m_sel, m_enable, busy, req0_ack, req1_ack, rsp_err} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000", {m_sel, m_enable, busy, req0_ack, req1_ack, rsp_err});
        else pass_cnt++;
        chk_cnt++;
        if ({m_addr, m_wdata, rsp_rdata, m_wr} !== 85'b0)
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h wr=%b want all 0", m_addr, m_wdata, rsp_rdata, m_wr);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        m_ready = 1; m_rdata = 32'hDEADBEEF;
        req0_valid = 1; req0_wr = 0; req0_addr = 20'h02004;
        tick();
        chk_cnt++;
        if ({m_sel, m_enable, busy} !== 3'b101 || m_addr !== 20'h02004)
            $display("FAIL rd_setup: sel/en/busy=%b addr=%h want 101 02004", {m_sel, m_enable, busy}, m_addr);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({m_sel, m_enable, req0_ack} !== 3'b110)
            $display("FAIL rd_access: sel/en/ack=%b want 110", {m_sel, m_enable, req0_ack});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({req0_ack, req1_ack, rsp_err, m_sel} !== 4'b1000 || rsp_rdata !== 32'hDEADBEEF)
            $display("FAIL rd_ack: ack0/ack1/err/sel=%b rdata=%h want 1000 deadbeef",
                     {req0_ack, req1_ack, rsp_err, m_sel}, rsp_rdata);
        else pass_cnt++;
        req0_valid = 0;
        tick();
        chk_cnt++;
        if ({req0_ack, busy} !== 2'b00 || rsp_rdata !== 32'hDEADBEEF)
            $display("FAIL rd_after: ack/busy=%b rdata=%h want 00 deadbeef", {req0_ack, busy}, rsp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_round_robin;
        int order[$];
        int last_cyc;
        int gaps_ok;
        int both;
        // fresh reset so last_gnt is 1 and requester 0 wins the first tie
        rst = 1; tick(); rst = 0;
        m_ready = 1; m_rdata = 32'h1234_5678;
        req0_valid = 1; req0_wr = 0; req0_addr = 20'h02000;
        req1_valid = 1; req1_wr = 0; req1_addr = 20'h04000;
        last_cyc = -1; gaps_ok = 1; both = 0;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            tick();
            if (req0_ack && req1_ack) both = 1;
            if (req0_ack || req1_ack) begin
                order.push_back(req1_ack ? 1 : 0);
                if (last_cyc >= 0 && c - last_cyc != 3) gaps_ok = 0;
                last_cyc = c;
                if (order.size() == 4) begin
                    req0_valid = 0; req1_valid = 0;
                end
            end
        end
        chk_cnt++;
        if (order.size() != 4)
            $display("FAIL rr_count: got %0d acks want 4", order.size());
        else begin
            pass_cnt++;
            chk_cnt++;
            if (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1)
                $display("FAIL rr_order: got %0d%0d%0d%0d want 0101", order[0], order[1], order[2], order[3]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (both != 0 || gaps_ok != 1)
            $display("FAIL rr_pulse: both=%0d gaps_ok=%0d want 0 1", both, gaps_ok);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({req0_ack, req1_ack, busy} !== 3'b000)
            $display("FAIL rr_idle: ack0/ack1/busy=%b want 000", {req0_ack, req1_ack, busy});
        else pass_cnt++;
    endtask

    task automatic test_wait_states_slverr;
        int stable;
        m_ready = 0; m_slverr = 0; m_rdata = 32'hCAFE_F00D;
        req1_valid = 1; req1_wr = 1; req1_addr = 20'h0A010; req1_wdata = 32'h55;
        tick();
        chk_cnt++;
        if ({m_sel, m_enable, m_wr} !== 3'b101 || m_addr !== 20'h0A010 || m_wdata !== 32'h55)
            $display("FAIL wr_setup: sel/en/wr=%b addr=%h wdata=%h want 101 0a010 55",
                     {m_sel, m_enable, m_wr}, m_addr, m_wdata);
        else pass_cnt++;
        // changed fields after grant must be ignored
        req1_addr = 20'h0F0F0; req1_wdata = 32'hFFFF_FFFF;
        stable = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (m_addr !== 20'h0A010 || m_wdata !== 32'h55 || m_enable !== 1'b1 || req1_ack !== 1'b0)
                stable = 0;
        end
        chk_cnt++;
        if (stable != 1) $display("FAIL wr_stable: got %0d want 1", stable);
        else pass_cnt++;
        m_ready = 1; m_slverr = 1;
        tick();
        chk_cnt++;
        if ({req1_ack, req0_ack, rsp_err, m_sel} !== 4'b1010 || rsp_rdata !== 32'h0)
            $display("FAIL wr_ack: ack1/ack0/err/sel=%b rdata=%h want 1010 0",
                     {req1_ack, req0_ack, rsp_err, m_sel}, rsp_rdata);
        else pass_cnt++;
        req1_valid = 0; m_slverr = 0;
        tick();
    endtask

    task automatic test_decerr;
        int sel_seen;
        m_ready = 1; m_rdata = 32'h1111_2222;
        req0_valid = 1; req0_wr = 0; req0_addr = 20'h00100;
        sel_seen = 0;
        tick();
        if (m_sel) sel_seen = 1;
        chk_cnt++;
        if ({busy, req0_ack} !== 2'b10)
            $display("FAIL dec_wait: busy/ack=%b want 10", {busy, req0_ack});
        else pass_cnt++;
        tick();
        if (m_sel) sel_seen = 1;
        chk_cnt++;
        if ({req0_ack, rsp_err} !== 2'b11 || rsp_rdata !== 32'h0)
            $display("FAIL dec_ack: ack/err=%b rdata=%h want 11 0", {req0_ack, rsp_err}, rsp_rdata);
        else pass_cnt++;
        req0_valid = 0;
        tick();
        chk_cnt++;
        if (sel_seen != 0) $display("FAIL dec_nosel: sel_seen=%0d want 0", sel_seen);
        else pass_cnt++;
    endtask

    task automatic test_timeout;
        int ack_early;
        m_ready = 0;
        req0_valid = 1; req0_wr = 0; req0_addr = 20'h04000;
        tick(); // SETUP
        ack_early = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (req0_ack || !m_enable) ack_early = 1;
        end
        chk_cnt++;
        if (ack_early != 0) $display("FAIL to_wait: early=%0d want 0", ack_early);
        else pass_cnt++;
        tick();
`ifdef APB_TIMEOUT_EN
        chk_cnt++;
        if ({req0_ack, rsp_err, m_sel} !== 3'b110 || rsp_rdata !== 32'h0)
            $display("FAIL to_ack: ack/err/sel=%b rdata=%h want 110 0", {req0_ack, rsp_err, m_sel}, rsp_rdata);
        else pass_cnt++;
        req0_valid = 0;
        tick();
`else
        req0_valid = 0;
        ack_early = 0;
        for (int i = 0; i < 10; i++) begin
            if (req0_ack || !m_enable) ack_early = 1;
            tick();
        end
        chk_cnt++;
        if (ack_early != 0) $display("FAIL to_noack: ack_or_drop=%0d want 0", ack_early);
        else pass_cnt++;
        rst = 1; tick(); rst = 0;
`endif
    endtask

    task automatic test_reset_mid_access;
        m_ready = 0;
        req0_valid = 1; req0_wr = 0; req0_addr = 20'h06000;
        tick(); tick();
        chk_cnt++;
        if ({m_sel, m_enable} !== 2'b11)
            $display("FAIL rst_pre: sel/en=%b want 11", {m_sel, m_enable});
        else pass_cnt++;
        rst = 1;
        tick();
        chk_cnt++;
        if ({m_sel, m_enable, busy, req0_ack, req1_ack} !== 5'b0)
            $display("FAIL rst_mid: sel/en/busy/ack0/ack1=%b want 00000", {m_sel, m_enable, busy, req0_ack, req1_ack});
        else pass_cnt++;
        rst = 0;
        m_ready = 1;
        req1_valid = 1; req1_wr = 0; req1_addr = 20'h08000;
        tick(); tick(); tick();
        chk_cnt++;
        if ({req0_ack, req1_ack} !== 2'b10)
            $display("FAIL rst_tie: ack0/ack1=%b want 10", {req0_ack, req1_ack});
        else pass_cnt++;
        req0_valid = 0; req1_valid = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_wait_states_slverr();
        test_decerr();
        test_timeout();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
